mem_bus_arbiter: RTL and testbench

- Shares the single byte-wide synchronous sample/coefficient memory (MemAddr, MemData inout, MemWrite, MemClk) between two requesters.
- Typical use: port 0 is the Filter tap engine; port 1 is the coefficient/sample loader.
- Per-port request/grant handshake, round-robin arbitration, and a Lock input so multi-byte sequences (3-byte sample, 6-byte tap fetch) stay atomic.
- Owns the tristate MemData driver and read-data capture.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/mem_bus_arbiter_rr_select.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-port sample/coefficient memory arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int NUM_PORTS = 2;

  localparam logic [15:0] SAMPLE_ADDR = 16'h0000;
  localparam logic [15:0] FILTER_ADDR = 16'h8000;

  // Ownership state for a given port index.
  function automatic state_t own_state(input logic port);
    return port ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_select.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to the favoured port.
module rr_select
  import mem_bus_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 ptr,
  output logic                 winner
);

  // Winner decode; with no request the pointer value is passed through unused.
  always_comb begin
    winner = ptr;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ptr;
      default: winner = ptr;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the byte-wide synchronous memory between the tap engine (port 0) and the
// loader (port 1), with locked multi-byte tenures, tristate data drive and read capture.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_LOCK = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Lock0,
  input  logic              Lock1,
  input  logic              Wr0,
  input  logic              Wr1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData0,
  input  logic [DATA_W-1:0] WData1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic [DATA_W-1:0] RData0,
  output logic [DATA_W-1:0] RData1,
  output logic              RValid0,
  output logic              RValid1,
  output logic [ADDR_W-1:0] MemAddr,
  inout  wire  [DATA_W-1:0] MemData,
  output logic              MemWrite,
  output logic              MemClk
);

  // Counter never holds MAX_LOCK itself: it clears on the transfer that reaches it.
  localparam int LCW = $clog2(MAX_LOCK + 2);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

  state_t               state_r, state_s;
  logic                 rr_r, rr_s;
  logic [LCW-1:0]       lock_cnt_r, lock_cnt_s;
  logic [1:0]           gnt_r, gnt_s;

  logic [NUM_PORTS-1:0] req_s;
  logic                 pick_s;
  logic                 own_s;
  logic                 accept_s;
  logic                 own_lock_s;
  logic                 other_req_s;
  logic                 forced_s;
  logic                 release_s;

  logic [ADDR_W-1:0]    mem_addr_r, mem_addr_s;
  logic                 mem_write_r, mem_write_s;
  logic [DATA_W-1:0]    wdata_r, wdata_s;
  logic                 rd_pend_r, rd_pend_s;
  logic                 rd_port_r, rd_port_s;

  logic [DATA_W-1:0]    rdata0_r, rdata1_r;
  logic [1:0]           rvalid_r;

  assign req_s = {Req1, Req0};

  rr_select u_rr_select (
    .req    (req_s),
    .ptr    (rr_r),
    .winner (pick_s)
  );

  // Current-owner view of the request/lock inputs and the release decision.
  always_comb begin
    own_s       = (state_r == OWN1);
    accept_s    = ((state_r == OWN0) && Req0) || ((state_r == OWN1) && Req1);
    own_lock_s  = own_s ? Lock1 : Lock0;
    other_req_s = own_s ? Req0 : Req1;
    if (MAX_LOCK != 0) begin
      forced_s = accept_s && (lock_cnt_r == LOCK_LAST);
    end else begin
      forced_s = 1'b0;
    end
    release_s = (state_r != IDLE) && (!own_lock_s || forced_s);
  end

  // State, round-robin pointer, lock counter and grant registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r    <= IDLE;
      rr_r       <= 1'b0;
      lock_cnt_r <= {LCW{1'b0}};
      gnt_r      <= 2'b00;
    end else begin
      state_r    <= state_s;
      rr_r       <= rr_s;
      lock_cnt_r <= lock_cnt_s;
      gnt_r      <= gnt_s;
    end
  end

  // Next-state: handover on release goes straight to the other port if it is waiting.
  always_comb begin
    state_s    = state_r;
    rr_s       = rr_r;
    lock_cnt_s = lock_cnt_r;
    case (state_r)
      IDLE: begin
        if (|req_s) begin
          state_s = own_state(pick_s);
        end else begin
          state_s = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (release_s) begin
          state_s    = other_req_s ? own_state(~own_s) : IDLE;
          rr_s       = ~own_s;
          lock_cnt_s = {LCW{1'b0}};
        end else if (accept_s) begin
          lock_cnt_s = lock_cnt_r + LCW'(1);
        end else begin
          lock_cnt_s = lock_cnt_r;
        end
      end
      default: begin
        state_s    = IDLE;
        lock_cnt_s = {LCW{1'b0}};
      end
    endcase
  end

  // Outputs: grant decode of the next state and the memory command of an accepted transfer.
  always_comb begin
    case (state_s)
      OWN0:    gnt_s = 2'b01;
      OWN1:    gnt_s = 2'b10;
      default: gnt_s = 2'b00;
    endcase
    mem_addr_s  = mem_addr_r;
    mem_write_s = 1'b0;
    wdata_s     = wdata_r;
    rd_pend_s   = 1'b0;
    rd_port_s   = rd_port_r;
    if (accept_s) begin
      mem_addr_s  = own_s ? Addr1 : Addr0;
      mem_write_s = own_s ? Wr1 : Wr0;
      wdata_s     = own_s ? WData1 : WData0;
      rd_pend_s   = !(own_s ? Wr1 : Wr0);
      rd_port_s   = own_s;
    end else begin
      mem_write_s = 1'b0;
    end
  end

  // Memory command registers; each command lives for exactly one cycle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_write_r <= 1'b0;
      wdata_r     <= {DATA_W{1'b0}};
      rd_pend_r   <= 1'b0;
      rd_port_r   <= 1'b0;
    end else begin
      mem_addr_r  <= mem_addr_s;
      mem_write_r <= mem_write_s;
      wdata_r     <= wdata_s;
      rd_pend_r   <= rd_pend_s;
      rd_port_r   <= rd_port_s;
    end
  end

  // Read capture: memory presented data at the MemClk rise, taken here one edge after acceptance.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rdata0_r <= {DATA_W{1'b0}};
      rdata1_r <= {DATA_W{1'b0}};
      rvalid_r <= 2'b00;
    end else begin
      rvalid_r <= {rd_pend_r & rd_port_r, rd_pend_r & ~rd_port_r};
      if (rd_pend_r && !rd_port_r) begin
        rdata0_r <= MemData;
      end
      if (rd_pend_r && rd_port_r) begin
        rdata1_r <= MemData;
      end
    end
  end

  assign Gnt0     = gnt_r[0];
  assign Gnt1     = gnt_r[1];
  assign RData0   = rdata0_r;
  assign RData1   = rdata1_r;
  assign RValid0  = rvalid_r[0];
  assign RValid1  = rvalid_r[1];
  assign MemAddr  = mem_addr_r;
  assign MemWrite = mem_write_r;
  assign MemData  = mem_write_r ? wdata_r : {DATA_W{1'bz}};
  assign MemClk   = ~Clock;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: an unlimited-lock arbiter and a MAX_LOCK=4 arbiter on modelled memories.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  logic        Clock, Reset;
  logic        req0, req1, lock0, lock1, wr0, wr1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;

  logic        gnt0, gnt1, rvalid0, rvalid1, mem_write, mem_clk;
  logic [7:0]  rdata0, rdata1;
  logic [15:0] mem_addr;
  wire  [7:0]  mem_data;

  logic        gnt0_m, gnt1_m, rvalid0_m, rvalid1_m, mem_write_m, mem_clk_m;
  logic [7:0]  rdata0_m, rdata1_m;
  logic [15:0] mem_addr_m;
  wire  [7:0]  mem_data_m;

  int tests = 0;
  int fails = 0;
  int rv0_cnt = 0;
  bit mon_en = 1'b0;

  logic [7:0]  exp_rd0[$];
  logic [7:0]  exp_rd1[$];
  logic [23:0] exp_wr[$];

  logic [7:0]  mem [0:65535];
  bit          wr_v [0:65535];
  logic [7:0]  mem_q, mem_q_m;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_LOCK(0)) dut (
    .Clock(Clock), .Reset(Reset),
    .Req0(req0), .Req1(req1), .Lock0(lock0), .Lock1(lock1),
    .Wr0(wr0), .Wr1(wr1), .Addr0(addr0), .Addr1(addr1),
    .WData0(wdata0), .WData1(wdata1),
    .Gnt0(gnt0), .Gnt1(gnt1), .RData0(rdata0), .RData1(rdata1),
    .RValid0(rvalid0), .RValid1(rvalid1),
    .MemAddr(mem_addr), .MemData(mem_data), .MemWrite(mem_write), .MemClk(mem_clk)
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_LOCK(4)) dut_m (
    .Clock(Clock), .Reset(Reset),
    .Req0(req0), .Req1(req1), .Lock0(lock0), .Lock1(lock1),
    .Wr0(wr0), .Wr1(wr1), .Addr0(addr0), .Addr1(addr1),
    .WData0(wdata0), .WData1(wdata1),
    .Gnt0(gnt0_m), .Gnt1(gnt1_m), .RData0(rdata0_m), .RData1(rdata1_m),
    .RValid0(rvalid0_m), .RValid1(rvalid1_m),
    .MemAddr(mem_addr_m), .MemData(mem_data_m), .MemWrite(mem_write_m), .MemClk(mem_clk_m)
  );

  // Background content of never-written locations.
  function automatic logic [7:0] pat(input logic [15:0] a);
    if (a == 16'h8001) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Expected read value: location 0002 was written with A5 by test_write_p0.
  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return (a == 16'h0002) ? 8'hA5 : pat(a);
  endfunction

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous memory models clocked on MemClk rise.
  always @(posedge mem_clk) begin
    if (mem_write) begin
      mem[mem_addr]  <= mem_data;
      wr_v[mem_addr] <= 1'b1;
    end else begin
      mem_q <= wr_v[mem_addr] ? mem[mem_addr] : pat(mem_addr);
    end
  end

  always @(posedge mem_clk_m) begin
    if (!mem_write_m) mem_q_m <= wr_v[mem_addr_m] ? mem[mem_addr_m] : pat(mem_addr_m);
  end

  assign mem_data   = mem_write   ? 8'hzz : mem_q;
  assign mem_data_m = mem_write_m ? 8'hzz : mem_q_m;

  // Scoreboard monitor for the unlimited-lock instance.
  initial begin
    logic [7:0]  e;
    logic [23:0] w;
    forever begin
      @(negedge Clock);
      if (mon_en && Reset) begin
        if (rvalid0) begin
          rv0_cnt++;
          tests++;
          if (exp_rd0.size() == 0) begin
            fails++; $display("FAIL rvalid0_extra: got RData0=%h, required no strobe", rdata0);
          end else begin
            e = exp_rd0.pop_front();
            if (rdata0 !== e) begin fails++; $display("FAIL rdata0: got %h, required %h", rdata0, e); end
          end
        end
        if (rvalid1) begin
          tests++;
          if (exp_rd1.size() == 0) begin
            fails++; $display("FAIL rvalid1_extra: got RData1=%h, required no strobe", rdata1);
          end else begin
            e = exp_rd1.pop_front();
            if (rdata1 !== e) begin fails++; $display("FAIL rdata1: got %h, required %h", rdata1, e); end
          end
        end
        if (mem_write) begin
          tests++;
          if (exp_wr.size() == 0) begin
            fails++; $display("FAIL memwrite_extra: got addr=%h data=%h, required no write", mem_addr, mem_data);
          end else begin
            w = exp_wr.pop_front();
            if ({mem_addr, mem_data} !== w) begin
              fails++; $display("FAIL memwrite: got %h/%h, required %h/%h", mem_addr, mem_data, w[23:8], w[7:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    wr0 = 1'b0; wr1 = 1'b0; addr0 = 16'h0000; addr1 = 16'h0000;
    wdata0 = 8'h00; wdata1 = 8'h00;
  endtask

  task automatic apply_reset();
    idle_inputs();
    exp_rd0.delete(); exp_rd1.delete(); exp_wr.delete();
    Reset = 1'b0;
    tick(); tick();
    Reset = 1'b1;
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_rd0.size() + exp_rd1.size() + exp_wr.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d/%0d/%0d outstanding, required 0/0/0",
               name, exp_rd0.size(), exp_rd1.size(), exp_wr.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    req0 = 1'b1;
    Reset = 1'b0;
    #12;
    tests++;
    if ({gnt1, gnt0, mem_write, rvalid1, rvalid0} !== 5'b00000 || mem_addr !== 16'h0000) begin
      fails++; $display("FAIL reset_ctrl: got gnt=%b%b we=%b rv=%b%b addr=%h, required all 0",
                        gnt1, gnt0, mem_write, rvalid1, rvalid0, mem_addr);
    end
    tests++;
    if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
      fails++; $display("FAIL reset_rdata: got %h/%h, required 00/00", rdata0, rdata1);
    end
    tests++;
    if (mem_data !== 8'h5A) begin
      fails++; $display("FAIL reset_memdata: got %h, required 5a from memory (bus released)", mem_data);
    end
    tick();
    Reset = 1'b1;
    tick();
    tests++;
    if ({gnt1, gnt0} !== 2'b01) begin
      fails++; $display("FAIL reset_first_grant: got gnt=%b%b, required 01", gnt1, gnt0);
    end
    req0 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_write_p0();
    apply_reset();
    req0 = 1'b1; lock0 = 1'b0; wr0 = 1'b1; addr0 = 16'h0002; wdata0 = 8'hA5;
    tick();
    tests++;
    if (gnt0 !== 1'b1 || mem_write !== 1'b0) begin
      fails++; $display("FAIL write_grant: got gnt0=%b we=%b, required 1/0", gnt0, mem_write);
    end
    exp_wr.push_back({16'h0002, 8'hA5});
    tick();
    req0 = 1'b0; wr0 = 1'b0;
    tests++;
    if (gnt0 !== 1'b0 || mem_write !== 1'b1 || mem_addr !== 16'h0002 || mem_data !== 8'hA5) begin
      fails++; $display("FAIL write_cycle: got gnt0=%b we=%b addr=%h data=%h, required 0/1/0002/a5",
                        gnt0, mem_write, mem_addr, mem_data);
    end
    tick();
    tests++;
    if (mem_write !== 1'b0 || mem_addr !== 16'h0002 || {gnt1, gnt0} !== 2'b00 || rvalid0 !== 1'b0) begin
      fails++; $display("FAIL write_after: got we=%b addr=%h gnt=%b%b rv0=%b, required 0/0002/00/0",
                        mem_write, mem_addr, gnt1, gnt0, rvalid0);
    end
    tick();
    check_drained("write");
  endtask

  task automatic test_read_p1();
    apply_reset();
    req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h8001;
    tick();
    tests++;
    if ({gnt1, gnt0} !== 2'b10) begin
      fails++; $display("FAIL read_grant: got gnt=%b%b, required 10", gnt1, gnt0);
    end
    exp_rd1.push_back(8'h3C);
    tick();
    req1 = 1'b0;
    tests++;
    if (gnt1 !== 1'b0 || mem_addr !== 16'h8001 || mem_write !== 1'b0 || rvalid1 !== 1'b0) begin
      fails++; $display("FAIL read_accept: got gnt1=%b addr=%h we=%b rv1=%b, required 0/8001/0/0",
                        gnt1, mem_addr, mem_write, rvalid1);
    end
    tick();
    tests++;
    if (rvalid1 !== 1'b1 || rdata1 !== 8'h3C || rvalid0 !== 1'b0) begin
      fails++; $display("FAIL read_data: got rv1=%b rdata1=%h rv0=%b, required 1/3c/0", rvalid1, rdata1, rvalid0);
    end
    tick();
    tests++;
    if (rvalid1 !== 1'b0) begin
      fails++; $display("FAIL read_pulse: got rv1=%b, required 0", rvalid1);
    end
    check_drained("read");
  endtask

  task automatic test_contention();
    logic [15:0] a;
    apply_reset();
    req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = 16'h0010; addr1 = 16'h8010;
    tick();
    tests++;
    if ({gnt1, gnt0} !== 2'b01) begin
      fails++; $display("FAIL contend_first: got gnt=%b%b, required 01", gnt1, gnt0);
    end
    for (int k = 0; k < 8; k++) begin
      addr0 = 16'h0010 + 16'(k);
      addr1 = 16'h8010 + 16'(k);
      a = (k % 2 == 0) ? addr0 : addr1;
      if (k % 2 == 0) exp_rd0.push_back(ref_rd(a));
      else            exp_rd1.push_back(ref_rd(a));
      tick();
      tests++;
      if ({gnt1, gnt0} !== ((k % 2 == 0) ? 2'b10 : 2'b01) || mem_addr !== a || mem_write !== 1'b0) begin
        fails++; $display("FAIL contend_%0d: got gnt=%b%b addr=%h, required %s/%h",
                          k, gnt1, gnt0, mem_addr, (k % 2 == 0) ? "10" : "01", a);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();
    tests++;
    if ({gnt1, gnt0} !== 2'b00) begin
      fails++; $display("FAIL contend_idle: got gnt=%b%b, required 00", gnt1, gnt0);
    end
    check_drained("contend");
  endtask

  task automatic test_lock_atomic();
    logic [15:0] la [6];
    la[0] = FILTER_ADDR;        la[1] = FILTER_ADDR + 16'd1; la[2] = FILTER_ADDR + 16'd2;
    la[3] = SAMPLE_ADDR;        la[4] = SAMPLE_ADDR + 16'd1; la[5] = SAMPLE_ADDR + 16'd2;
    apply_reset();
    req0 = 1'b1; lock0 = 1'b1; wr0 = 1'b0; addr0 = la[0];
    tick();
    req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h8100;
    rv0_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      addr0 = la[i];
      lock0 = (i < 5) ? 1'b1 : 1'b0;
      exp_rd0.push_back(ref_rd(la[i]));
      tick();
      tests++;
      if ({gnt1, gnt0} !== ((i < 5) ? 2'b01 : 2'b10)) begin
        fails++; $display("FAIL lock_gnt_%0d: got gnt=%b%b, required %s", i, gnt1, gnt0, (i < 5) ? "01" : "10");
      end
    end
    req0 = 1'b0; lock0 = 1'b0;
    exp_rd1.push_back(ref_rd(16'h8100));
    tick();
    req1 = 1'b0;
    tick(); tick();
    tests++;
    if (rv0_cnt != 6) begin
      fails++; $display("FAIL lock_rvalid0_count: got %0d, required 6", rv0_cnt);
    end
    check_drained("lock");
  endtask

  task automatic test_forced_release();
    logic [7:0] fq[$];
    logic [7:0] e;
    apply_reset();
    mon_en = 1'b0;
    req0 = 1'b1; lock0 = 1'b1; wr0 = 1'b0; addr0 = FILTER_ADDR;
    tick();
    tests++;
    if (gnt0_m !== 1'b1) begin
      fails++; $display("FAIL forced_grant: got gnt0=%b, required 1", gnt0_m);
    end
    req1 = 1'b1; lock1 = 1'b0; wr1 = 1'b0; addr1 = 16'h8200;
    for (int i = 0; i < 4; i++) begin
      addr0 = FILTER_ADDR + 16'(i);
      fq.push_back(pat(FILTER_ADDR + 16'(i)));
      tick();
      tests++;
      if ({gnt1_m, gnt0_m} !== ((i < 3) ? 2'b01 : 2'b10)) begin
        fails++; $display("FAIL forced_gnt_%0d: got gnt=%b%b, required %s", i, gnt1_m, gnt0_m, (i < 3) ? "01" : "10");
      end
      if (i > 0) begin
        e = fq.pop_front();
        tests++;
        if (rvalid0_m !== 1'b1 || rdata0_m !== e) begin
          fails++; $display("FAIL forced_rd_%0d: got rv0=%b data=%h, required 1/%h", i - 1, rvalid0_m, rdata0_m, e);
        end
      end
    end
    req0 = 1'b0; lock0 = 1'b0; lock1 = 1'b1;
    tick();
    e = fq.pop_front();
    tests++;
    if (rvalid0_m !== 1'b1 || rdata0_m !== e || mem_addr_m !== 16'h8200) begin
      fails++; $display("FAIL forced_rd_3: got rv0=%b data=%h addr=%h, required 1/%h/8200", rvalid0_m, rdata0_m, mem_addr_m, e);
    end
    wr1 = 1'b1; addr1 = 16'h8201; wdata1 = 8'h77;
    tick();
    #1;
    tests++;
    if ({gnt1_m, mem_write_m, rvalid1_m} !== 3'b111 || rdata1_m !== pat(16'h8200)) begin
      fails++; $display("FAIL forced_pre_reset: got gnt1=%b we=%b rv1=%b data=%h, required 1/1/1/%h",
                        gnt1_m, mem_write_m, rvalid1_m, rdata1_m, pat(16'h8200));
    end
    Reset = 1'b0;
    #1;
    tests++;
    if ({gnt1_m, gnt0_m, mem_write_m, rvalid1_m} !== 4'b0000 || mem_addr_m !== 16'h0000 || rdata1_m !== 8'h00) begin
      fails++; $display("FAIL forced_async_reset: got gnt=%b%b we=%b rv1=%b addr=%h data=%h, required all 0",
                        gnt1_m, gnt0_m, mem_write_m, rvalid1_m, mem_addr_m, rdata1_m);
    end
    idle_inputs();
    tick();
    Reset = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    Reset = 1'b0;
    test_reset();
    mon_en = 1'b1;
    test_write_p0();
    test_read_p1();
    test_contention();
    test_lock_atomic();
    test_forced_release();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
